ucount_seq8: RTL and testbench

//  Command-driven sequencer that drives the control side of an 8-bit up/down counter (ucounter8-class).

---
 rtl/ucount_seq8_pkg.sv | 34 +++
 rtl/ucount_seq8_if.sv | 30 +++
 rtl/ucount_seq8_stepctr.sv | 31 +++
 rtl/ucount_seq8.sv | 164 ++++++++++++++++
 tb/tb_ucount_seq8.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ucount_seq8_pkg.sv
// Shared constants for the ucount_seq8 command sequencer: opcodes, FSM encoding
// and the opcode-to-first-state decode.
package ucount_seq8_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int STEPW_DEF = 8;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_SET  = 2'd2;
    localparam logic [1:0] OP_RSV  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SET    = 3'd2,
        ST_RUN    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // A zero-length RUN skips straight to SETTLE; the reserved opcode answers at once.
    function automatic state_t op_next_state(input logic [1:0] op, input logic steps_zero);
        state_t st;
        case (op)
            OP_LOAD: st = ST_LOAD;
            OP_RUN:  st = steps_zero ? ST_SETTLE : ST_RUN;
            OP_SET:  st = ST_SET;
            default: st = ST_DONE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/ucount_seq8_if.sv
// Command / response handshake bundle between a host master and the sequencer.
interface ucount_seq8_if
    import ucount_seq8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEPW = STEPW_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_val;
    logic             cmd_dir;
    logic             cmd_wrap;
    logic [STEPW-1:0] cmd_steps;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_count;
    logic             rsp_ovf;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_val, cmd_dir, cmd_wrap, cmd_steps, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_count, rsp_ovf, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_val, cmd_dir, cmd_wrap, cmd_steps, rsp_ready,
        output cmd_ready, rsp_valid, rsp_count, rsp_ovf, rsp_err
    );
endinterface

// File: rtl/ucount_seq8_stepctr.sv
// Loadable down-counter of remaining RUN cycles; 'last' marks the final step.
module ucount_seq8_stepctr #(
    parameter int STEPW = 8
) (
    input  logic             clk,
    input  logic             _areset,
    input  logic             load,
    input  logic [STEPW-1:0] load_val,
    input  logic             dec,
    output logic             last
);
    localparam logic [STEPW-1:0] ONE = {{(STEPW-1){1'b0}}, 1'b1};

    logic [STEPW-1:0] cnt_r;

    // Remaining-step register; saturates at zero so all-ones never wraps.
    always_ff @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == ONE);

endmodule

// File: rtl/ucount_seq8.sv
// Command sequencer driving the control pins of an 8-bit up/down counter and
// reporting the resulting count and sticky overflow on a response handshake.
module ucount_seq8
    import ucount_seq8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEPW = STEPW_DEF
) (
    input  logic             clk,
    input  logic             _areset,
    ucount_seq8_if.slave     bus,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_preld_val,
    output logic             cnt_aset,
    output logic             cnt_updown,
    output logic             cnt_wrapstop,
    output logic             cnt_carry_in,
    input  logic [WIDTH-1:0] cnt_dcount,
    input  logic             cnt_overflow
);
    state_t           state_r, state_s;
    logic             accept_s, last_s, run_dec_s;
    logic             cmd_ready_r, cmd_ready_s;
    logic             rsp_valid_r, rsp_valid_s;
    logic [WIDTH-1:0] rsp_count_r, rsp_count_s;
    logic             rsp_ovf_r, rsp_ovf_s;
    logic             rsp_err_r, rsp_err_s;
    logic             cnt_load_r, cnt_load_s;
    logic [WIDTH-1:0] cnt_preld_val_r, cnt_preld_val_s;
    logic             cnt_aset_r, cnt_aset_s;
    logic             cnt_updown_r, cnt_updown_s;
    logic             cnt_wrapstop_r, cnt_wrapstop_s;
    logic             cnt_carry_in_r, cnt_carry_in_s;

    assign run_dec_s = (state_r == ST_RUN);

    ucount_seq8_stepctr #(.STEPW(STEPW)) u_stepctr (
        .clk      (clk),
        ._areset  (_areset),
        .load     (accept_s),
        .load_val (bus.cmd_steps),
        .dec      (run_dec_s),
        .last     (last_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && cmd_ready_r && bus.cmd_valid;
        state_s  = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = op_next_state(bus.cmd_op, (bus.cmd_steps == '0));
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD:   state_s = ST_SETTLE;
            ST_SET:    state_s = ST_SETTLE;
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_SETTLE: state_s = ST_DONE;
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default:   state_s = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state itself.
        cmd_ready_s    = (state_s == ST_IDLE);
        rsp_valid_s    = (state_s == ST_DONE);
        cnt_load_s     = (state_s == ST_LOAD);
        cnt_aset_s     = (state_s == ST_SET);
        cnt_carry_in_s = (state_s == ST_RUN);

        if (accept_s && (state_s == ST_RUN)) begin
            cnt_updown_s   = bus.cmd_dir;
            cnt_wrapstop_s = bus.cmd_wrap;
        end else begin
            cnt_updown_s   = cnt_updown_r;
            cnt_wrapstop_s = cnt_wrapstop_r;
        end

        if (accept_s) begin
            cnt_preld_val_s = bus.cmd_val;
            rsp_count_s     = '0;
            rsp_ovf_s       = 1'b0;
            rsp_err_s       = (bus.cmd_op == OP_RSV);
        end else begin
            cnt_preld_val_s = cnt_preld_val_r;
            rsp_err_s       = rsp_err_r;
            if (state_r == ST_SETTLE) begin
                rsp_count_s = cnt_dcount;
            end else begin
                rsp_count_s = rsp_count_r;
            end
            if ((state_r == ST_RUN) || (state_r == ST_SETTLE)) begin
                rsp_ovf_s = rsp_ovf_r | cnt_overflow;
            end else begin
                rsp_ovf_s = rsp_ovf_r;
            end
        end
    end

    // Output registers; direction and wrap mode come out of reset as up/wrap.
    always_ff @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            cmd_ready_r     <= 1'b0;
            rsp_valid_r     <= 1'b0;
            rsp_count_r     <= '0;
            rsp_ovf_r       <= 1'b0;
            rsp_err_r       <= 1'b0;
            cnt_load_r      <= 1'b0;
            cnt_preld_val_r <= '0;
            cnt_aset_r      <= 1'b0;
            cnt_updown_r    <= 1'b1;
            cnt_wrapstop_r  <= 1'b1;
            cnt_carry_in_r  <= 1'b0;
        end else begin
            cmd_ready_r     <= cmd_ready_s;
            rsp_valid_r     <= rsp_valid_s;
            rsp_count_r     <= rsp_count_s;
            rsp_ovf_r       <= rsp_ovf_s;
            rsp_err_r       <= rsp_err_s;
            cnt_load_r      <= cnt_load_s;
            cnt_preld_val_r <= cnt_preld_val_s;
            cnt_aset_r      <= cnt_aset_s;
            cnt_updown_r    <= cnt_updown_s;
            cnt_wrapstop_r  <= cnt_wrapstop_s;
            cnt_carry_in_r  <= cnt_carry_in_s;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_count = rsp_count_r;
    assign bus.rsp_ovf   = rsp_ovf_r;
    assign bus.rsp_err   = rsp_err_r;
    assign cnt_load      = cnt_load_r;
    assign cnt_preld_val = cnt_preld_val_r;
    assign cnt_aset      = cnt_aset_r;
    assign cnt_updown    = cnt_updown_r;
    assign cnt_wrapstop  = cnt_wrapstop_r;
    assign cnt_carry_in  = cnt_carry_in_r;

endmodule

// File: tb/tb_ucount_seq8.sv
// Scoreboard bench for ucount_seq8: an 8-bit counter model closes the loop and a
// closed-form reference predicts each response, its latency and its strobes.
module tb_ucount_seq8;
    import ucount_seq8_pkg::*;

    typedef struct {
        logic [7:0] cnt;
        bit         ovf;
        bit         err;
        int         lat;
        int         carries;
        int         loads;
        int         asets;
        int         first_off;
    } exp_t;

    logic       clk = 1'b0;
    logic       areset_n = 1'b0;
    logic       cnt_load, cnt_aset, cnt_updown, cnt_wrapstop, cnt_carry_in;
    logic [7:0] cnt_preld_val;
    logic [7:0] dcount;
    logic       covf;
    bit         hold_rdy = 1'b1;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] ref_cnt = 8'h00;
    exp_t       sb_q[$];

    ucount_seq8_if #(.WIDTH(8), .STEPW(8)) bus ();

    ucount_seq8 #(.WIDTH(8), .STEPW(8)) dut (
        .clk           (clk),
        ._areset       (areset_n),
        .bus           (bus),
        .cnt_load      (cnt_load),
        .cnt_preld_val (cnt_preld_val),
        .cnt_aset      (cnt_aset),
        .cnt_updown    (cnt_updown),
        .cnt_wrapstop  (cnt_wrapstop),
        .cnt_carry_in  (cnt_carry_in),
        .cnt_dcount    (dcount),
        .cnt_overflow  (covf)
    );

    always #5 clk = ~clk;

    // Behavioural ucounter8: overflow is a registered flag for an enabled step taken at a limit.
    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            dcount <= 8'h00; covf <= 1'b0;
        end else if (cnt_aset) begin
            dcount <= 8'hFF; covf <= 1'b0;
        end else if (cnt_load) begin
            dcount <= cnt_preld_val; covf <= 1'b0;
        end else if (cnt_carry_in && cnt_updown) begin
            covf   <= (dcount == 8'hFF);
            dcount <= (dcount != 8'hFF) ? dcount + 8'h01 : (cnt_wrapstop ? 8'h00 : 8'hFF);
        end else if (cnt_carry_in) begin
            covf   <= (dcount == 8'h00);
            dcount <= (dcount != 8'h00) ? dcount - 8'h01 : (cnt_wrapstop ? 8'hFF : 8'h00);
        end else begin
            covf <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] val, input bit dir,
                        input bit wrap, input logic [7:0] steps);
        exp_t e;
        int   t, guard;
        @(posedge clk); #2;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_val = val;
        bus.cmd_dir = dir; bus.cmd_wrap = wrap; bus.cmd_steps = steps;
        guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 1000) begin
            @(negedge clk); guard++;
        end
        if (!bus.cmd_ready) begin
            check("cmd_accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        e.cnt = 8'h00; e.ovf = 1'b0; e.err = 1'b0; e.carries = 0;
        e.loads = 0; e.asets = 0; e.first_off = 1; e.lat = 3;
        case (op)
            OP_LOAD: begin ref_cnt = val; e.cnt = val; e.loads = 1; end
            OP_SET:  begin ref_cnt = 8'hFF; e.cnt = 8'hFF; e.asets = 1; end
            OP_RUN: begin
                t = dir ? int'(ref_cnt) + int'(steps) : int'(ref_cnt) - int'(steps);
                e.ovf = (t > 255) || (t < 0);
                if (wrap)          t = (t + 256) % 256;
                else if (t > 255)  t = 255;
                else if (t < 0)    t = 0;
                ref_cnt   = 8'(t);
                e.cnt     = ref_cnt;
                e.carries = int'(steps);
                e.lat     = (steps == 8'd0) ? 2 : int'(steps) + 2;
                e.first_off = (steps == 8'd0) ? -1 : 1;
            end
            default: begin e.err = 1'b1; e.lat = 1; e.first_off = -1; end
        endcase
        sb_q.push_back(e);
        @(posedge clk); #2;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'($urandom); bus.cmd_val = 8'($urandom);
        bus.cmd_steps = 8'($urandom); bus.cmd_dir = 1'($urandom); bus.cmd_wrap = 1'($urandom);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 2000) begin
            @(negedge clk); g++;
        end
        check("drain_queue_empty", sb_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Response ready: random backpressure unless the main sequence forces a stall.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            bus.rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: strobe/latency bookkeeping from the command handshake, scoreboard pop on response.
    initial begin : monitor
        int         samp, hs_samp, carries, loads, asets, first_off;
        bit         prev_valid, prev_rsp_hs;
        logic [9:0] held;
        exp_t       e;
        samp = 0; hs_samp = 0; carries = 0; loads = 0; asets = 0; first_off = -1;
        prev_valid = 1'b0; prev_rsp_hs = 1'b0; held = '0;
        forever begin
            @(negedge clk);
            samp++;
            if (!areset_n) begin
                prev_valid = 1'b0; prev_rsp_hs = 1'b0;
                continue;
            end
            if (prev_rsp_hs) check("ready_after_rsp", bus.cmd_ready, 1);
            if (bus.cmd_valid && bus.cmd_ready) begin
                hs_samp = samp; carries = 0; loads = 0; asets = 0; first_off = -1;
            end else begin
                carries += int'(cnt_carry_in);
                loads   += int'(cnt_load);
                asets   += int'(cnt_aset);
                if ((cnt_load || cnt_aset || cnt_carry_in) && first_off < 0)
                    first_off = samp - hs_samp;
            end
            if (bus.rsp_valid) check("no_accept_while_rsp", bus.cmd_ready, 0);
            if (bus.rsp_valid && !prev_valid) begin
                check("rsp_has_cmd", int'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("rsp_count", bus.rsp_count, e.cnt);
                    check("rsp_ovf", bus.rsp_ovf, e.ovf);
                    check("rsp_err", bus.rsp_err, e.err);
                    check("rsp_latency", samp - hs_samp, e.lat);
                    check("carry_cycles", carries, e.carries);
                    check("load_cycles", loads, e.loads);
                    check("aset_cycles", asets, e.asets);
                    check("first_strobe_offset", first_off, e.first_off);
                end
                held = {bus.rsp_count, bus.rsp_ovf, bus.rsp_err};
            end else if (bus.rsp_valid) begin
                check("rsp_stable", {bus.rsp_count, bus.rsp_ovf, bus.rsp_err}, held);
            end
            prev_valid  = bus.rsp_valid;
            prev_rsp_hs = bus.rsp_valid && bus.rsp_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_val = 8'h00;
        bus.cmd_dir = 1'b0; bus.cmd_wrap = 1'b0; bus.cmd_steps = 8'h00;

        // Reset values, then ready one edge after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_updown_wrap", {cnt_updown, cnt_wrapstop}, 2'b11);
        @(posedge clk); #2; areset_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("post_rst_cmd_ready", bus.cmd_ready, 1);
        check("post_rst_strobes", {bus.rsp_valid, cnt_carry_in, cnt_load, cnt_aset}, 4'b0000);
        hold_rdy = 1'b0;

        // Directed sequence around the limits.
        send(OP_LOAD, 8'hC5, 1'b0, 1'b0, 8'd0);
        send(OP_RUN,  8'h00, 1'b1, 1'b1, 8'd5);
        send(OP_RUN,  8'h00, 1'b0, 1'b1, 8'd5);
        send(OP_SET,  8'h00, 1'b0, 1'b0, 8'd0);
        send(OP_RUN,  8'h00, 1'b1, 1'b1, 8'd5);
        send(OP_SET,  8'h00, 1'b0, 1'b0, 8'd0);
        send(OP_RUN,  8'h00, 1'b1, 1'b0, 8'd5);
        send(OP_RUN,  8'h00, 1'b1, 1'b1, 8'd0);
        send(OP_RSV,  8'hAA, 1'b1, 1'b1, 8'd7);
        send(OP_LOAD, 8'h10, 1'b0, 1'b0, 8'd0);
        send(OP_RUN,  8'h00, 1'b1, 1'b1, 8'hFF);
        drain();

        // Forced response stall.
        hold_rdy = 1'b1;
        send(OP_LOAD, 8'h5A, 1'b0, 1'b0, 8'd0);
        g = 0;
        while (!bus.rsp_valid && g < 50) begin @(negedge clk); g++; end
        repeat (4) @(negedge clk);
        check("stall_rsp_valid", bus.rsp_valid, 1);
        check("stall_cmd_ready", bus.cmd_ready, 0);
        check("stall_rsp_count", bus.rsp_count, 8'h5A);
        hold_rdy = 1'b0;
        drain();

        // Randomised commands biased towards the counter limits.
        for (int i = 0; i < 40; i++) begin
            int         r;
            logic [1:0] op;
            logic [7:0] val;
            r   = $urandom_range(0, 9);
            op  = (r < 2) ? OP_LOAD : (r == 2) ? OP_SET : (r == 3) ? OP_RSV : OP_RUN;
            val = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7))
                                              : 8'($urandom_range(248, 255));
            if ($urandom_range(0, 3) == 0) val = 8'($urandom);
            send(op, val, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 20)));
        end
        drain();

        // Asynchronous reset in the middle of a long down-count, stop mode.
        send(OP_LOAD, 8'h80, 1'b0, 1'b0, 8'd0);
        drain();
        @(posedge clk); #2;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_RUN; bus.cmd_val = 8'h00;
        bus.cmd_dir = 1'b0; bus.cmd_wrap = 1'b0; bus.cmd_steps = 8'd200;
        g = 0;
        @(negedge clk);
        while (!bus.cmd_ready && g < 100) begin @(negedge clk); g++; end
        @(posedge clk); #2; bus.cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_run_carry", cnt_carry_in, 1);
        check("mid_run_dir_wrap", {cnt_updown, cnt_wrapstop}, 2'b00);
        #2 areset_n = 1'b0;
        #1;
        check("async_rst_ready_valid", {bus.cmd_ready, bus.rsp_valid}, 2'b00);
        check("async_rst_strobes", {cnt_carry_in, cnt_load, cnt_aset}, 3'b000);
        check("async_rst_dir_wrap", {cnt_updown, cnt_wrapstop}, 2'b11);
        check("async_rst_rsp", {bus.rsp_count, bus.rsp_ovf, bus.rsp_err}, 10'h000);
        ref_cnt = 8'h00;
        @(posedge clk); #2; areset_n = 1'b1;

        // Recovery: the sequencer must work normally again.
        send(OP_RUN,  8'h00, 1'b0, 1'b1, 8'd3);
        send(OP_LOAD, 8'h3C, 1'b0, 1'b0, 8'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
